// File: rtl/fetch_stage_pkg.sv
//------------------------------------------------------------------------------
// fetch_stage_pkg : shared constants, state encodings and helpers for the
//                   MIPS instruction-fetch stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_stage_pkg;

    localparam logic [31:0] c_reset_pc      = 32'h0000_3000;
    localparam logic [31:0] c_nop_word      = 32'h0000_0000;
    localparam logic [31:0] c_pc_align_mask = 32'hFFFF_FFFC;

    localparam logic [0:0] c_st_req  = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & c_pc_align_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
//------------------------------------------------------------------------------
// fetch_stage_if_id_reg : IF/ID pipeline register with load/bubble/hold and
//                         flush-over-everything priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    if_id_t r_if_id;

    // Flush beats a pending load, so the dropped instruction never reaches decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id <= '{pc: 32'h0, instr: NOP_WORD, valid: 1'b0};
        end else if (i_flush) begin
            r_if_id <= '{pc: 32'h0, instr: NOP_WORD, valid: 1'b0};
        end else if (i_load) begin
            r_if_id <= '{pc: i_pc, instr: i_instr, valid: 1'b1};
        end else if (i_bubble) begin
            r_if_id <= '{pc: i_pc, instr: NOP_WORD, valid: 1'b0};
        end
    end

    assign o_pc    = r_if_id.pc;
    assign o_instr = r_if_id.instr;
    assign o_valid = r_if_id.valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : MIPS IF stage - PC register, req/ack fetch FSM, parked word
//               for stalls, and the accepted-instruction counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic [31:0] fetch_count
);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_fetch_count;

    logic        w_in_req;
    logic        w_ack;
    logic        w_advance;
    logic        w_park;
    logic        w_bubble;
    logic [31:0] w_deliver_instr;

    assign w_in_req = (r_state == c_st_req);
    assign w_ack    = w_in_req & imem_ack;

    // An instruction leaves the stage either straight from memory or from the parked slot.
    assign w_advance       = w_in_req ? (w_ack & ~stall) : ~stall;
    assign w_park          = w_ack & stall;
    assign w_bubble        = w_in_req & ~imem_ack & ~stall;
    assign w_deliver_instr = w_in_req ? imem_rdata : r_hold_instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_st_req;
            r_pc          <= RESET_PC;
            r_hold_instr  <= NOP_WORD;
            r_fetch_count <= 32'h0;
        end else begin
            if (w_park) begin
                r_state      <= c_st_hold;
                r_hold_instr <= imem_rdata;
            end else if (!w_in_req && !stall) begin
                r_state <= c_st_req;
            end

            if (w_advance) begin
                r_pc <= align_pc(next_pc);
            end

            if (w_advance && !flush) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    fetch_stage_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_advance),
        .i_bubble (w_bubble),
        .i_flush  (flush),
        .i_pc     (r_pc),
        .i_instr  (w_deliver_instr),
        .o_pc     (pc_id),
        .o_instr  (instr_id),
        .o_valid  (valid_id)
    );

    // Request is gated by reset directly so it drops the instant reset asserts.
    assign imem_req    = w_in_req & reset;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage : directed and randomized bench for fetch_stage against a
//                  rule-level reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    wire         imem_req;
    wire  [31:0] imem_addr;
    wire  [31:0] pc;
    wire  [31:0] pc_id;
    wire  [31:0] instr_id;
    wire         valid_id;
    wire  [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_word, m_pcid, m_instr, m_cnt;
    logic        m_hold, m_valid;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .valid_id    (valid_id),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_word = NOP; m_pcid = 32'h0; m_instr = NOP;
        m_cnt = 32'h0; m_hold = 1'b0; m_valid = 1'b0;
    endtask

    task automatic check_all();
        chk("pc",          pc,                m_pc);
        chk("imem_addr",   imem_addr,         m_pc);
        chk("imem_req",    {31'h0, imem_req}, {31'h0, ~m_hold});
        chk("pc_id",       pc_id,             m_pcid);
        chk("instr_id",    instr_id,          m_instr);
        chk("valid_id",    {31'h0, valid_id}, {31'h0, m_valid});
        chk("fetch_count", fetch_count,       m_cnt);
    endtask

    // One clock: check outputs, drive inputs, advance the model by the rules.
    task automatic step(input logic st, input logic fl, input logic ack,
                        input logic [31:0] rd, input logic [31:0] npc);
        logic        deliver;
        logic [31:0] w;
        #1;
        check_all();
        stall = st; flush = fl; imem_ack = ack; imem_rdata = rd; next_pc = npc;
        deliver = 1'b0;
        w = NOP;
        if (m_hold) begin
            if (!st) begin deliver = 1'b1; w = m_word; m_hold = 1'b0; end
        end else if (ack) begin
            if (st) begin m_word = rd; m_hold = 1'b1; end
            else    begin deliver = 1'b1; w = rd; end
        end else if (!st) begin
            m_pcid = m_pc; m_instr = NOP; m_valid = 1'b0;
        end
        if (deliver) begin
            if (!fl) begin
                m_pcid = m_pc; m_instr = w; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            m_pc = {npc[31:2], 2'b00};
        end
        if (fl) begin m_pcid = 32'h0; m_instr = NOP; m_valid = 1'b0; end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, observed before any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_pc",       pc,                RST_PC);
        chk("rst_valid_id", {31'h0, valid_id}, 32'h0);
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc_id",    pc_id,             32'h0);
        chk("rst_count",    fetch_count,       32'h0);
        stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] cnt0, hold_pc;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'h0; next_pc = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait memory, sequential fetch
        step(0, 0, 1, 32'h2408_0001, m_pc + 32'd4);
        chk("first_pc_id", pc_id, 32'h0000_3000);
        chk("first_valid", {31'h0, valid_id}, 32'h1);
        step(0, 0, 1, 32'h2408_0001, m_pc + 32'd4);
        step(0, 0, 1, 32'h2408_0001, m_pc + 32'd4);
        chk("count_after_3", fetch_count, 32'd3);

        // Two wait cycles then ack
        step(0, 0, 0, 32'h0, m_pc + 32'd4);
        step(0, 0, 0, 32'h0, m_pc + 32'd4);
        chk("wait_valid", {31'h0, valid_id}, 32'h0);
        chk("wait_instr", instr_id, 32'h0);
        chk("wait_addr",  imem_addr, 32'h0000_300C);
        step(0, 0, 1, 32'h8C09_0004, m_pc + 32'd4);
        chk("after_wait_pc_id", pc_id, 32'h0000_300C);

        // Ack under stall, parked for three cycles
        hold_pc = m_pc;
        step(1, 0, 1, 32'hAABB_CCDD, m_pc + 32'd4);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        step(1, 0, 1, 32'h1111_2222, m_pc + 32'd4);
        step(1, 0, 0, 32'h0, m_pc + 32'd4);
        step(0, 0, 0, 32'h0, 32'h0000_3100);
        chk("release_pc_id", pc_id, hold_pc);
        chk("release_instr", instr_id, 32'hAABB_CCDD);
        chk("release_pc",    pc, 32'h0000_3100);

        // Jump with misaligned target
        step(0, 0, 1, 32'h0800_0000, 32'h0040_0013);
        chk("jump_pc", pc, 32'h0040_0010);

        // Flush together with stall and ack
        cnt0 = m_cnt;
        step(1, 1, 1, 32'h5555_6666, m_pc + 32'd4);
        chk("flush_valid", {31'h0, valid_id}, 32'h0);
        chk("flush_pc_id", pc_id, 32'h0);
        chk("flush_count", fetch_count, cnt0);
        step(0, 0, 0, 32'h0, m_pc + 32'd4);

        // Reset during a wait, then during HOLD
        step(0, 0, 0, 32'h0, m_pc + 32'd4);
        do_reset();
        step(0, 0, 1, 32'h2408_0001, m_pc + 32'd4);
        step(1, 0, 1, 32'h2408_0002, m_pc + 32'd4);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl, ack;
            logic [31:0] npc;
            st  = ($urandom_range(0, 99) < 30);
            fl  = ($urandom_range(0, 99) < 10);
            ack = ($urandom_range(0, 99) < 55);
            npc = ($urandom_range(0, 3) == 0) ? $urandom : (m_pc + 32'd4);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(st, fl, ack, $urandom, npc);
            end
        end
        #1;
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
